gp_cmd_sequencer: RTL and testbench
===================================

Name: gp_cmd_sequencer

Overview:
- Execution controller for the GP engine command buffer.
- On `start`, fetches `cmd_count` 64-bit commands in order over the buffer's FSM read port.
- Decodes each command and drives single-beat transactions on the engine's bus-master request interface.
- Executes plain WRITE commands and two-entry read-modify-write (RWM) pairs; reports `busy`, `done` and `error` to the engine control registers.

Parameters:
- CMD_WIDTH, 64, command width.
- ADDR_WIDTH, 32, command-buffer index width and bus address width.
- DATA_WIDTH, 32, bus data width.
- CMD_STRIDE, 4, `cmd_addr` increment per command.
- MAX_CMDS, 128, upper bound on `cmd_count`.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begin sequence (ignored unless IDLE)
- cmd_count  in  8  number of commands to execute, sampled on start
- cmd_rd_en  out  1  command fetch request
- cmd_addr  out  ADDR_WIDTH  command index
- cmd_rd_valid  in  1  fetched command valid
- cmd_out  in  CMD_WIDTH  fetched command
- mst_valid  out  1  bus request valid
- mst_addr  out  ADDR_WIDTH  bus address
- mst_wr_data  out  DATA_WIDTH  bus write data
- mst_rd0_wr1  out  1  1 = write, 0 = read
- mst_ready  in  1  request accepted when mst_valid && mst_ready
- mst_rd_data  in  DATA_WIDTH  read return data
- mst_rd_valid  in  1  read return strobe
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse; sequence completed
- error  out  1  one-cycle pulse; sequence aborted
- err_code  out  2  sticky cause: 0 none, 1 illegal type, 2 RWM not followed by WRITE, 3 bad count

Behaviour:
- Reset state: all outputs 0, state IDLE, `cmd_addr` = 0.
- Command format: `{addr[31:2], data[31:0], type[1:0]}`.
  - Bus address = `{cmd[63:34], 2'b00}`.
  - Data = `cmd[33:2]`.
  - Type: 00 = WRITE, 01 = RWM, 10/11 = illegal.
- IDLE: on `start`:
  - `cmd_count` = 0 or > MAX_CMDS: `error` pulse, `err_code` = 3, stay IDLE.
  - Otherwise: latch count, `cmd_addr` = 0, clear `err_code`, go FETCH.
- FETCH: assert `cmd_rd_en` for one cycle, go WAIT_CMD.
- WAIT_CMD: wait for `cmd_rd_valid`, latch `cmd_out`, go DECODE. No timeout.
- DECODE:
  - WRITE: go ISSUE_WR.
  - RWM: save address and mask (data field), advance `cmd_addr` by CMD_STRIDE, decrement remaining count, go FETCH2.
    - If the RWM is the last command: go ERROR, `err_code` = 2.
  - Illegal type: go ERROR, `err_code` = 1.
- FETCH2/WAIT2: fetch the next entry as in FETCH/WAIT_CMD.
  - Its type must be WRITE; otherwise go ERROR, `err_code` = 2.
  - Its data field is the value; its address field is ignored.
- RMW_RD: drive `mst_valid`=1, `mst_rd0_wr1`=0, `mst_addr` = saved address. Hold until `mst_ready`, then go RMW_WAIT.
- RMW_WAIT: on `mst_rd_valid`, compute `new = (rd & ~mask) | (value & mask)`, go RMW_WR.
- RMW_WR / ISSUE_WR: drive `mst_valid`=1, `mst_rd0_wr1`=1 with address and data.
  - Request fields are stable while `mst_valid` && !`mst_ready`.
  - On accept: deassert `mst_valid`, advance `cmd_addr`, decrement count.
  - Count = 0: go DONE. Otherwise go FETCH.
- DONE: `done` pulse, go IDLE.
- ERROR: `error` pulse, go IDLE. No further bus requests.
- `busy` = 1 in every state except IDLE. `start` while busy is ignored.
- At most one outstanding bus request; `mst_valid` never asserted while a read return is pending.
- `mst_rd_valid` outside RMW_WAIT is ignored.
- `cmd_addr` index arithmetic is modulo 2^ADDR_WIDTH.
- `rst_n` low mid-sequence: immediate return to IDLE, outputs cleared, no `done`/`error` pulse.

Decomposition:
- Package `gp_engine_pkg`:
  - Command type localparams (WRITE 2'b00, RWM 2'b01).
  - State enum `seq_state_t`.
  - `err_code` enum.
  - Command field slice functions (`cmd_addr_f`, `cmd_data_f`, `cmd_type_f`).
- Sub-module `gp_rmw_merge`: small combinational mask-merge unit. Everything else stays in one FSM module.

Test Plan:
- Single WRITE: count=1, cmd `{addr 0x4000_0010, data 0xDEAD_BEEF, 00}` → one write to 0x4000_0010 with data 0xDEADBEEF, then `done` pulse; `busy` low the cycle after.
- RWM pair: mask 0x0000_00FF at 0x4000_0020, value 0x0000_0055, bus read returns 0x1234_5678 → write 0x1234_5655 to 0x4000_0020; `cmd_addr` sequence 0, 4.
- Backpressure: `mst_ready` held low 5 cycles during a write → `mst_addr`/`mst_wr_data`/`mst_valid` stable all 5 cycles; exactly one accept.
- Illegal type 2'b10 in the second of 3 commands → first write issued, then `error` pulse with `err_code`=1, no further bus activity.
- RWM as last command (count=1), and RWM followed by RWM → `error`, `err_code`=2, no bus read issued.
- `rst_n` asserted during RMW_WAIT → all outputs 0 next cycle, state IDLE; a new `start` with count=2 runs normally.

Source files
------------

// File: rtl/gp_cmd_sequencer_pkg.sv
// Shared types for the GP engine command sequencer: command encoding, FSM states, error causes.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package gp_engine_pkg;

  localparam int CMD_W  = 64;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  // Command type encodings; anything else is illegal
  localparam logic [1:0] CMD_WRITE = 2'b00;
  localparam logic [1:0] CMD_RWM   = 2'b01;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_CMD,
    S_DECODE,
    S_FETCH2,
    S_WAIT2,
    S_RMW_RD,
    S_RMW_WAIT,
    S_RMW_WR,
    S_ISSUE_WR,
    S_DONE,
    S_ERROR
  } seq_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_ILLEGAL  = 2'd1,
    ERR_RWM_PAIR = 2'd2,
    ERR_COUNT    = 2'd3
  } err_code_t;

  // Word-aligned bus address carried in the top 30 bits
  function automatic logic [ADDR_W-1:0] cmd_addr_f(input logic [CMD_W-1:0] cmd);
    return {cmd[63:34], 2'b00};
  endfunction

  // Write data, or mask/value for a read-modify-write pair
  function automatic logic [DATA_W-1:0] cmd_data_f(input logic [CMD_W-1:0] cmd);
    return cmd[33:2];
  endfunction

  function automatic logic [1:0] cmd_type_f(input logic [CMD_W-1:0] cmd);
    return cmd[1:0];
  endfunction

endpackage

// File: rtl/gp_cmd_sequencer_if.sv
// Command-buffer read port plus single-beat bus-master request channel of the GP engine.
// Latency: none (wiring only).
// Backpressure: mst_ready stalls requests; command fetch has no backpressure, only a valid strobe.
interface gp_cmd_sequencer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CMD_WIDTH  = 64
);

  logic                  cmd_rd_en;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic                  cmd_rd_valid;
  logic [CMD_WIDTH-1:0]  cmd_out;

  logic                  mst_valid;
  logic [ADDR_WIDTH-1:0] mst_addr;
  logic [DATA_WIDTH-1:0] mst_wr_data;
  logic                  mst_rd0_wr1;
  logic                  mst_ready;
  logic [DATA_WIDTH-1:0] mst_rd_data;
  logic                  mst_rd_valid;

  // Sequencer side
  modport master (
    output cmd_rd_en, cmd_addr, mst_valid, mst_addr, mst_wr_data, mst_rd0_wr1,
    input  cmd_rd_valid, cmd_out, mst_ready, mst_rd_data, mst_rd_valid
  );

  // Command buffer / bus fabric side
  modport slave (
    input  cmd_rd_en, cmd_addr, mst_valid, mst_addr, mst_wr_data, mst_rd0_wr1,
    output cmd_rd_valid, cmd_out, mst_ready, mst_rd_data, mst_rd_valid
  );

endinterface

// File: rtl/gp_cmd_sequencer_rmw_merge.sv
// Mask merge for read-modify-write: masked bits come from value, the rest from the read data.
// Latency: combinational.
// Backpressure: none.
module gp_rmw_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic [DATA_WIDTH-1:0] mask,
  input  logic [DATA_WIDTH-1:0] value,
  output logic [DATA_WIDTH-1:0] merged
);

  assign merged = (rd_data & ~mask) | (value & mask);

endmodule

// File: rtl/gp_cmd_sequencer.sv
// Fetches cmd_count commands from the command buffer and executes WRITEs and RWM pairs on the bus.
// Latency: 5 cycles start-to-first-write; each further WRITE 4 cycles + stall, RWM adds fetch and read.
// Backpressure: request held stable until mst_ready; fetch waits indefinitely for cmd_rd_valid.
module gp_cmd_sequencer
  import gp_engine_pkg::*;
#(
  parameter int CMD_WIDTH  = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CMD_STRIDE = 4,
  parameter int MAX_CMDS   = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [7:0]           cmd_count,
  gp_cmd_sequencer_if.master   bus,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [1:0]           err_code
);

  localparam logic [8:0]            MAX_COUNT = 9'(MAX_CMDS);
  localparam logic [ADDR_WIDTH-1:0] STRIDE    = ADDR_WIDTH'(CMD_STRIDE);

  seq_state_t            state;
  err_code_t             err_q;
  logic [7:0]            remain;
  logic [CMD_WIDTH-1:0]  cmd_q;
  logic [ADDR_WIDTH-1:0] rmw_addr;
  logic [DATA_WIDTH-1:0] rmw_mask;
  logic [DATA_WIDTH-1:0] rmw_value;
  logic [DATA_WIDTH-1:0] merged;
  logic                  bad_count;

  assign err_code  = err_q;
  assign bad_count = (cmd_count == 8'd0) || ({1'b0, cmd_count} > MAX_COUNT);

  gp_rmw_merge #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_merge (
    .rd_data (bus.mst_rd_data),
    .mask    (rmw_mask),
    .value   (rmw_value),
    .merged  (merged)
  );

  // Sequencer FSM; every output is registered and set on entry to the state that owns it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      err_q           <= ERR_NONE;
      remain          <= '0;
      cmd_q           <= '0;
      rmw_addr        <= '0;
      rmw_mask        <= '0;
      rmw_value       <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
      bus.cmd_rd_en   <= 1'b0;
      bus.cmd_addr    <= '0;
      bus.mst_valid   <= 1'b0;
      bus.mst_addr    <= '0;
      bus.mst_wr_data <= '0;
      bus.mst_rd0_wr1 <= 1'b0;
    end else begin
      done          <= 1'b0;
      error         <= 1'b0;
      bus.cmd_rd_en <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            if (bad_count) begin
              // Rejected without leaving IDLE: busy never rises
              error <= 1'b1;
              err_q <= ERR_COUNT;
            end else begin
              remain        <= cmd_count;
              bus.cmd_addr  <= '0;
              err_q         <= ERR_NONE;
              busy          <= 1'b1;
              bus.cmd_rd_en <= 1'b1;
              state         <= S_FETCH;
            end
          end
        end

        S_FETCH: state <= S_WAIT_CMD;

        S_WAIT_CMD: begin
          if (bus.cmd_rd_valid) begin
            cmd_q <= bus.cmd_out;
            state <= S_DECODE;
          end
        end

        S_DECODE: begin
          case (cmd_type_f(cmd_q))
            CMD_WRITE: begin
              bus.mst_valid   <= 1'b1;
              bus.mst_rd0_wr1 <= 1'b1;
              bus.mst_addr    <= cmd_addr_f(cmd_q);
              bus.mst_wr_data <= cmd_data_f(cmd_q);
              state           <= S_ISSUE_WR;
            end
            CMD_RWM: begin
              if (remain == 8'd1) begin
                // No entry left to supply the value half of the pair
                error <= 1'b1;
                err_q <= ERR_RWM_PAIR;
                state <= S_ERROR;
              end else begin
                rmw_addr      <= cmd_addr_f(cmd_q);
                rmw_mask      <= cmd_data_f(cmd_q);
                bus.cmd_addr  <= bus.cmd_addr + STRIDE;
                remain        <= remain - 8'd1;
                bus.cmd_rd_en <= 1'b1;
                state         <= S_FETCH2;
              end
            end
            default: begin
              error <= 1'b1;
              err_q <= ERR_ILLEGAL;
              state <= S_ERROR;
            end
          endcase
        end

        S_FETCH2: state <= S_WAIT2;

        S_WAIT2: begin
          if (bus.cmd_rd_valid) begin
            if (cmd_type_f(bus.cmd_out) == CMD_WRITE) begin
              // Only the data field of the second entry matters
              rmw_value       <= cmd_data_f(bus.cmd_out);
              bus.mst_valid   <= 1'b1;
              bus.mst_rd0_wr1 <= 1'b0;
              bus.mst_addr    <= rmw_addr;
              state           <= S_RMW_RD;
            end else begin
              error <= 1'b1;
              err_q <= ERR_RWM_PAIR;
              state <= S_ERROR;
            end
          end
        end

        S_RMW_RD: begin
          if (bus.mst_ready) begin
            bus.mst_valid <= 1'b0;
            state         <= S_RMW_WAIT;
          end
        end

        S_RMW_WAIT: begin
          if (bus.mst_rd_valid) begin
            bus.mst_wr_data <= merged;
            bus.mst_valid   <= 1'b1;
            bus.mst_rd0_wr1 <= 1'b1;
            state           <= S_RMW_WR;
          end
        end

        S_RMW_WR, S_ISSUE_WR: begin
          if (bus.mst_ready) begin
            bus.mst_valid <= 1'b0;
            bus.cmd_addr  <= bus.cmd_addr + STRIDE;
            remain        <= remain - 8'd1;
            if (remain == 8'd1) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              bus.cmd_rd_en <= 1'b1;
              state         <= S_FETCH;
            end
          end
        end

        S_DONE, S_ERROR: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          busy          <= 1'b0;
          bus.mst_valid <= 1'b0;
          state         <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gp_cmd_sequencer.sv
// Directed bench for gp_cmd_sequencer with a command-buffer model and a bus responder.
// Latency: fetch data returns two cycles after cmd_rd_en; read data two cycles after read accept.
// Backpressure: mst_ready held low for a programmable number of cycles per request.
module tb_gp_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] cmd_count = 8'd0;
  logic       busy, done, error;
  logic [1:0] err_code;

  int tests = 0;
  int fails = 0;

  logic [63:0] mem [0:127];
  int          stall_left = 0;
  bit          rd_ret_en = 1'b1;
  logic [31:0] rd_value = '0;
  int          rd_delay = 0;
  bit          pend = 1'b0;
  logic [31:0] pend_addr = '0;

  logic [31:0] acc_addr [$];
  logic [31:0] acc_data [$];
  logic        acc_wr   [$];
  logic [31:0] fetch_log [$];
  int          done_cnt = 0;
  int          err_cnt = 0;

  gp_cmd_sequencer_if bus ();

  gp_cmd_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cmd_count (cmd_count),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mk_cmd(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
    return {a[31:2], d, t};
  endfunction

  // Command buffer: one-cycle gap, then a one-cycle valid strobe
  initial begin
    bus.cmd_rd_valid = 1'b0;
    bus.cmd_out      = '0;
    forever begin
      @(posedge clk); #1;
      bus.cmd_rd_valid = pend;
      bus.cmd_out      = pend ? mem[pend_addr[8:2]] : 64'd0;
      pend             = bus.cmd_rd_en;
      if (bus.cmd_rd_en) begin
        pend_addr = bus.cmd_addr;
        fetch_log.push_back(bus.cmd_addr);
      end
    end
  end

  // Bus responder: programmable stall and delayed read return
  initial begin
    bus.mst_ready    = 1'b0;
    bus.mst_rd_valid = 1'b0;
    bus.mst_rd_data  = '0;
    forever begin
      @(posedge clk); #1;
      bus.mst_rd_valid = 1'b0;
      if (rd_delay > 0) begin
        rd_delay--;
        if (rd_delay == 0) begin
          bus.mst_rd_valid = 1'b1;
          bus.mst_rd_data  = rd_value;
        end
      end
      if (bus.mst_valid) begin
        if (stall_left > 0) begin
          bus.mst_ready = 1'b0;
          stall_left--;
        end else begin
          bus.mst_ready = 1'b1;
        end
      end else begin
        bus.mst_ready = 1'b0;
      end
    end
  end

  // Accept and pulse monitor
  initial begin
    forever begin
      @(negedge clk);
      if (bus.mst_valid && bus.mst_ready) begin
        acc_addr.push_back(bus.mst_addr);
        acc_data.push_back(bus.mst_wr_data);
        acc_wr.push_back(bus.mst_rd0_wr1);
        if (!bus.mst_rd0_wr1 && rd_ret_en) rd_delay = 2;
      end
      if (done)  done_cnt++;
      if (error) err_cnt++;
    end
  end

  task automatic clear_logs();
    repeat (3) @(negedge clk);
    acc_addr.delete();
    acc_data.delete();
    acc_wr.delete();
    fetch_log.delete();
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  task automatic kick(input logic [7:0] n);
    @(posedge clk); #1;
    cmd_count = n;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic wait_end(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done || error) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if ({busy, done, error} !== 3'b000) begin
      fails++; $display("FAIL reset_status: got %b expected 000", {busy, done, error});
    end
    tests++;
    if (err_code !== 2'd0) begin
      fails++; $display("FAIL reset_err_code: got %0d expected 0", err_code);
    end
    tests++;
    if ({bus.cmd_rd_en, bus.mst_valid, bus.mst_rd0_wr1} !== 3'b000) begin
      fails++; $display("FAIL reset_strobes: got %b expected 000", {bus.cmd_rd_en, bus.mst_valid, bus.mst_rd0_wr1});
    end
    tests++;
    if (bus.cmd_addr !== 32'd0) begin
      fails++; $display("FAIL reset_cmd_addr: got %h expected 0", bus.cmd_addr);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    bit ok;
    clear_logs();
    mem[0] = mk_cmd(32'h4000_0010, 32'hDEAD_BEEF, 2'b00);
    kick(8'd1);
    wait_end(ok);
    tests++;
    if (!ok || done !== 1'b1) begin
      fails++; $display("FAIL single_done: got done=%b ok=%b expected done=1", done, ok);
    end
    tests++;
    if (acc_addr.size() != 1 || acc_addr[0] !== 32'h4000_0010 || acc_data[0] !== 32'hDEAD_BEEF || acc_wr[0] !== 1'b1) begin
      fails++; $display("FAIL single_write: got %0d accepts first addr=%h data=%h expected 1 write 40000010/deadbeef",
                        acc_addr.size(), acc_addr.size() > 0 ? acc_addr[0] : 32'h0, acc_data.size() > 0 ? acc_data[0] : 32'h0);
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL single_busy_after: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_rmw_pair();
    bit ok;
    clear_logs();
    mem[0]   = mk_cmd(32'h4000_0020, 32'h0000_00FF, 2'b01);
    mem[1]   = mk_cmd(32'h7777_0000, 32'h0000_0055, 2'b00);
    rd_value = 32'h1234_5678;
    kick(8'd2);
    wait_end(ok);
    tests++;
    if (!ok || done !== 1'b1 || err_cnt != 0) begin
      fails++; $display("FAIL rmw_done: got done=%b errors=%0d expected done=1 errors=0", done, err_cnt);
    end
    tests++;
    if (acc_addr.size() != 2 || acc_wr[0] !== 1'b0 || acc_addr[0] !== 32'h4000_0020) begin
      fails++; $display("FAIL rmw_read: got %0d accepts expected read of 40000020 first", acc_addr.size());
    end
    tests++;
    if (acc_addr.size() != 2 || acc_wr[1] !== 1'b1 || acc_addr[1] !== 32'h4000_0020 || acc_data[1] !== 32'h1234_5655) begin
      fails++; $display("FAIL rmw_write: got data=%h expected write 12345655 to 40000020",
                        acc_data.size() > 1 ? acc_data[1] : 32'h0);
    end
    tests++;
    if (fetch_log.size() != 2 || fetch_log[0] !== 32'd0 || fetch_log[1] !== 32'd4) begin
      fails++; $display("FAIL rmw_cmd_addr: got %0d fetches expected indices 0,4", fetch_log.size());
    end
  endtask

  task automatic test_backpressure();
    bit ok, seen;
    int stalled, unstable;
    logic [31:0] ref_addr, ref_data;
    clear_logs();
    mem[0]     = mk_cmd(32'h4000_0100, 32'hA5A5_0001, 2'b00);
    stall_left = 5;
    kick(8'd1);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.mst_valid) begin seen = 1'b1; break; end
    end
    ref_addr = bus.mst_addr;
    ref_data = bus.mst_wr_data;
    stalled  = 0;
    unstable = 0;
    for (int i = 0; i < 20 && seen; i++) begin
      if (bus.mst_valid && !bus.mst_ready) begin
        stalled++;
        if (bus.mst_addr !== ref_addr || bus.mst_wr_data !== ref_data || bus.mst_rd0_wr1 !== 1'b1) unstable++;
      end else begin
        break;
      end
      @(negedge clk);
    end
    tests++;
    if (!seen || ref_addr !== 32'h4000_0100 || ref_data !== 32'hA5A5_0001) begin
      fails++; $display("FAIL bp_request: got addr=%h data=%h expected 40000100/a5a50001", ref_addr, ref_data);
    end
    tests++;
    if (stalled != 5 || unstable != 0) begin
      fails++; $display("FAIL bp_stable: got %0d stalled cycles %0d changed expected 5 stalled 0 changed", stalled, unstable);
    end
    wait_end(ok);
    tests++;
    if (!ok || done !== 1'b1 || acc_addr.size() != 1) begin
      fails++; $display("FAIL bp_accepts: got %0d accepts done=%b expected 1 accept and done", acc_addr.size(), done);
    end
  endtask

  task automatic test_illegal();
    bit ok;
    clear_logs();
    mem[0] = mk_cmd(32'h4000_0200, 32'h1111_2222, 2'b00);
    mem[1] = mk_cmd(32'h4000_0204, 32'h3333_4444, 2'b10);
    mem[2] = mk_cmd(32'h4000_0208, 32'h5555_6666, 2'b00);
    kick(8'd3);
    wait_end(ok);
    tests++;
    if (!ok || error !== 1'b1 || err_code !== 2'd1) begin
      fails++; $display("FAIL illegal_error: got error=%b code=%0d expected 1 1", error, err_code);
    end
    repeat (10) @(negedge clk);
    tests++;
    if (acc_addr.size() != 1 || acc_addr[0] !== 32'h4000_0200) begin
      fails++; $display("FAIL illegal_bus: got %0d accepts expected only write to 40000200", acc_addr.size());
    end
    tests++;
    if (err_cnt != 1 || done_cnt != 0 || fetch_log.size() != 2 || err_code !== 2'd1) begin
      fails++; $display("FAIL illegal_after: got errors=%0d dones=%0d fetches=%0d code=%0d expected 1 0 2 1",
                        err_cnt, done_cnt, fetch_log.size(), err_code);
    end
  endtask

  task automatic test_rwm_errors();
    bit ok;
    clear_logs();
    mem[0] = mk_cmd(32'h4000_0300, 32'h0000_00F0, 2'b01);
    kick(8'd1);
    wait_end(ok);
    tests++;
    if (!ok || error !== 1'b1 || err_code !== 2'd2) begin
      fails++; $display("FAIL rwm_last: got error=%b code=%0d expected 1 2", error, err_code);
    end
    repeat (5) @(negedge clk);
    tests++;
    if (acc_addr.size() != 0 || fetch_log.size() != 1) begin
      fails++; $display("FAIL rwm_last_bus: got %0d accepts %0d fetches expected 0 1", acc_addr.size(), fetch_log.size());
    end
    clear_logs();
    mem[1] = mk_cmd(32'h4000_0304, 32'h0000_000F, 2'b01);
    kick(8'd2);
    wait_end(ok);
    tests++;
    if (!ok || error !== 1'b1 || err_code !== 2'd2) begin
      fails++; $display("FAIL rwm_rwm: got error=%b code=%0d expected 1 2", error, err_code);
    end
    repeat (5) @(negedge clk);
    tests++;
    if (acc_addr.size() != 0 || fetch_log.size() != 2 || done_cnt != 0) begin
      fails++; $display("FAIL rwm_rwm_bus: got %0d accepts %0d fetches %0d dones expected 0 2 0",
                        acc_addr.size(), fetch_log.size(), done_cnt);
    end
  endtask

  task automatic test_bad_count();
    bit ok;
    clear_logs();
    kick(8'd0);
    wait_end(ok);
    tests++;
    if (!ok || error !== 1'b1 || err_code !== 2'd3 || busy !== 1'b0) begin
      fails++; $display("FAIL count_zero: got error=%b code=%0d busy=%b expected 1 3 0", error, err_code, busy);
    end
    kick(8'd129);
    wait_end(ok);
    tests++;
    if (!ok || error !== 1'b1 || err_code !== 2'd3 || busy !== 1'b0) begin
      fails++; $display("FAIL count_129: got error=%b code=%0d busy=%b expected 1 3 0", error, err_code, busy);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (fetch_log.size() != 0 || err_cnt != 2) begin
      fails++; $display("FAIL count_quiet: got %0d fetches %0d errors expected 0 2", fetch_log.size(), err_cnt);
    end
  endtask

  task automatic test_max_count();
    bit ok;
    int bad;
    clear_logs();
    for (int i = 0; i < 128; i++)
      mem[i] = mk_cmd(32'h5000_0000 + 32'(i * 4), 32'hC0DE_0000 ^ 32'(i), 2'b00);
    kick(8'd128);
    wait_end(ok);
    tests++;
    if (!ok || done !== 1'b1 || err_code !== 2'd0) begin
      fails++; $display("FAIL max_done: got done=%b code=%0d expected 1 0", done, err_code);
    end
    bad = 0;
    if (acc_addr.size() != 128) bad = 1000;
    else
      for (int i = 0; i < 128; i++)
        if (acc_addr[i] !== 32'h5000_0000 + 32'(i * 4) || acc_data[i] !== (32'hC0DE_0000 ^ 32'(i))) bad++;
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL max_writes: got %0d bad of %0d writes expected 0 bad of 128", bad, acc_addr.size());
    end
    tests++;
    if (fetch_log.size() != 128 || fetch_log[$] !== 32'd508) begin
      fails++; $display("FAIL max_cmd_addr: got %0d fetches expected 128 ending at index 508", fetch_log.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok, seen;
    clear_logs();
    mem[0]    = mk_cmd(32'h4000_0300, 32'h0000_FF00, 2'b01);
    mem[1]    = mk_cmd(32'h0000_0000, 32'h0000_AB00, 2'b00);
    rd_ret_en = 1'b0;
    kick(8'd2);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (acc_addr.size() >= 1) begin seen = 1'b1; break; end
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if (!seen || {busy, done, error, bus.cmd_rd_en, bus.mst_valid, bus.mst_rd0_wr1} !== 6'd0 ||
        bus.cmd_addr !== 32'd0 || bus.mst_addr !== 32'd0 || err_code !== 2'd0) begin
      fails++; $display("FAIL midreset_outputs: got flags=%b cmd_addr=%h mst_addr=%h read_seen=%b expected all 0, read seen",
                        {busy, done, error, bus.cmd_rd_en, bus.mst_valid, bus.mst_rd0_wr1}, bus.cmd_addr, bus.mst_addr, seen);
    end
    tests++;
    if (done_cnt != 0 || err_cnt != 0) begin
      fails++; $display("FAIL midreset_pulses: got dones=%0d errors=%0d expected 0 0", done_cnt, err_cnt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    rd_ret_en = 1'b1;
    rd_value  = 32'hCAFE_1234;
    clear_logs();
    kick(8'd2);
    wait_end(ok);
    tests++;
    if (!ok || done !== 1'b1 || acc_addr.size() != 2 || acc_data[1] !== 32'hCAFE_AB34 || acc_addr[1] !== 32'h4000_0300) begin
      fails++; $display("FAIL midreset_rerun: got done=%b accepts=%0d data=%h expected done, 2 accepts, cafeab34",
                        done, acc_addr.size(), acc_data.size() > 1 ? acc_data[1] : 32'h0);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = '0;
    test_reset();
    test_single_write();
    test_rmw_pair();
    test_backpressure();
    test_illegal();
    test_rwm_errors();
    test_bad_count();
    test_max_count();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
